icache_fetch_responder: RTL and testbench

// - Answers the program counter's instruction-address requests.
// - Consumes current_instr (byte address) and returns the addressed 32-bit instruction.
// - Direct-mapped instruction cache; a miss refills one line from main memory.
// - Drives Stall back to the program counter, so the PC holds its address until the word is delivered.

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_line_store.sv | 54 +++++
 rtl/icache_fetch_responder.sv | 103 ++++++++++
 tb/tb_icache_fetch_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared geometry, address-field widths and FSM state type for the
// instruction-cache fetch responder.
package icache_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned NUM_LINES  = 16;

    localparam int unsigned WOFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W       = ADDR_WIDTH - INDEX_W - WOFF_W - 2;
    localparam int unsigned LINE_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped tag/valid/data arrays: combinational hit and word read,
// one word-write port that also installs the tag and valid bit on the last word.
module icache_line_store
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    input  logic [WOFF_W-1:0]     rd_woff,
    output logic                  rd_hit_c,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    input  logic                  wr_en,
    input  logic                  wr_last,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [WOFF_W-1:0]     wr_woff,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        if (wr_en && wr_last) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index][wr_woff] <= wr_data;
            if (wr_last) begin
                tag_q[wr_index] <= wr_tag;
            end
        end
    end

    assign rd_hit_c  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data_c = data_q[rd_index][rd_woff];

endmodule

// File: rtl/icache_fetch_responder.sv
// Instruction fetch responder: zero-latency hits from a direct-mapped cache,
// one-line refill bursts from main memory on a miss, Stall back to the PC.
module icache_fetch_responder
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] current_instr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  Stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                   state_q, state_d;
    logic [WOFF_W-1:0]        beat_q, beat_d;
    logic [LINE_ADDR_W-1:0]   line_q, line_d;

    logic [WOFF_W-1:0]        req_woff;
    logic [INDEX_W-1:0]       req_index;
    logic [TAG_W-1:0]         req_tag;
    logic                     hit_c;
    logic [DATA_WIDTH-1:0]    rd_data_c;
    logic                     wr_en;
    logic                     wr_last;
    logic                     unused_byte_off;

    assign req_woff        = current_instr[2 +: WOFF_W];
    assign req_index       = current_instr[2 + WOFF_W +: INDEX_W];
    assign req_tag         = current_instr[ADDR_WIDTH-1 -: TAG_W];
    assign unused_byte_off = ^current_instr[1:0];

    icache_line_store u_store (
        .clk       (CLK),
        .rst       (RST),
        .rd_index  (req_index),
        .rd_tag    (req_tag),
        .rd_woff   (req_woff),
        .rd_hit_c  (hit_c),
        .rd_data_c (rd_data_c),
        .wr_en     (wr_en && !RST),
        .wr_last   (wr_last),
        .wr_index  (line_q[INDEX_W-1:0]),
        .wr_woff   (beat_q),
        .wr_tag    (line_q[LINE_ADDR_W-1:INDEX_W]),
        .wr_data   (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
        end
    end

    // Refill writes land in the latched line, so a PC change mid-burst cannot redirect them.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!hit_c) begin
                    line_d  = {req_tag, req_index};
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + WOFF_W'(1);
                    if (beat_q == WOFF_W'(LINE_WORDS - 1)) begin
                        wr_last = 1'b1;
                        beat_d  = '0;
                        state_d = FILL_DONE;
                    end
                end
            end
            FILL_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall and instr_out stay combinational so the PC sees them on the same edge.
    assign Stall     = RST || (state_q != IDLE) || !hit_c;
    assign instr_out = RST ? '0 : rd_data_c;
    assign mem_req   = !RST && (state_q == REFILL);
    assign mem_addr  = RST ? '0 : {line_q, {(WOFF_W + 2){1'b0}}};

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Randomized bench for icache_fetch_responder against a line-level cache model.
module tb_icache_fetch_responder;

    logic        CLK;
    logic        RST;
    logic [31:0] current_instr;
    logic [31:0] instr_out;
    logic        Stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    icache_fetch_responder dut (
        .CLK           (CLK),
        .RST           (RST),
        .current_instr (current_instr),
        .instr_out     (instr_out),
        .Stall         (Stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_data  [16][4];
    logic [31:0] fill_data [4];
    bit          use_fill  = 1'b0;
    bit          rand_gaps = 1'b0;
    bit          pat_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch of addr, starting 1ns after a rising edge and ending 1ns after
    // the edge that follows delivery. abort_after>=0 asserts RST once that many beats landed.
    task automatic fetch(input logic [31:0] addr, input int abort_after);
        int          idx;
        int          woff;
        int          beats;
        int          cyc;
        bit          v;
        logic [31:0] line_words [4];
        logic [31:0] line_addr;
        idx       = int'(addr[7:4]);
        woff      = int'(addr[3:2]);
        line_addr = addr & ~32'hF;
        current_instr = addr;
        mem_valid     = 1'b0;
        @(negedge CLK);
        if (m_valid[idx] && m_tag[idx] == addr[31:8]) begin
            check("hit_stall", 32'(Stall), 32'd0);
            check("hit_data", instr_out, m_data[idx][woff]);
            check("hit_memreq", 32'(mem_req), 32'd0);
            @(posedge CLK); #1;
            return;
        end
        check("miss_stall", 32'(Stall), 32'd1);
        check("miss_memreq", 32'(mem_req), 32'd0);
        @(posedge CLK); #1;
        beats = 0;
        cyc   = 0;
        while (beats < 4 && cyc < 64) begin
            if (abort_after >= 0 && beats == abort_after) begin
                RST       = 1'b1;
                mem_valid = 1'b0;
                @(negedge CLK);
                check("rst_memreq", 32'(mem_req), 32'd0);
                check("rst_stall", 32'(Stall), 32'd1);
                check("rst_instr", instr_out, 32'd0);
                check("rst_memaddr", mem_addr, 32'd0);
                @(posedge CLK); #1;
                RST = 1'b0;
                model_clear();
                return;
            end
            if (pat_q.size() > 0) v = pat_q.pop_front();
            else if (rand_gaps)   v = 1'($urandom_range(0, 1));
            else                  v = 1'b1;
            mem_valid = v;
            mem_rdata = (v && use_fill) ? fill_data[beats] : $urandom;
            @(negedge CLK);
            check("refill_req", 32'(mem_req), 32'd1);
            check("refill_addr", mem_addr, line_addr);
            check("refill_stall", 32'(Stall), 32'd1);
            if (v) begin
                line_words[beats] = mem_rdata;
                beats++;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        mem_valid = 1'b0;
        if (beats < 4) begin
            check("refill_timeout", 32'(beats), 32'd4);
            return;
        end
        @(negedge CLK);
        check("done_stall", 32'(Stall), 32'd1);
        check("done_req", 32'(mem_req), 32'd0);
        @(posedge CLK); #1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[31:8];
        for (int i = 0; i < 4; i++) m_data[idx][i] = line_words[i];
        @(negedge CLK);
        check("after_stall", 32'(Stall), 32'd0);
        check("after_data", instr_out, m_data[idx][woff]);
        check("after_memreq", 32'(mem_req), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] a;
        RST           = 1'b1;
        current_instr = 32'h0;
        mem_valid     = 1'b0;
        mem_rdata     = 32'h0;
        model_clear();
        @(posedge CLK); #1;
        @(negedge CLK);
        check("reset_stall", 32'(Stall), 32'd1);
        check("reset_instr", instr_out, 32'd0);
        check("reset_memaddr", mem_addr, 32'd0);
        check("reset_memreq", 32'(mem_req), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Cold miss with a known line, then same-line hits.
        fill_data[0] = 32'hA0; fill_data[1] = 32'hA1;
        fill_data[2] = 32'hA2; fill_data[3] = 32'hA3;
        use_fill = 1'b1;
        fetch(32'h0000_0010, -1);
        use_fill = 1'b0;
        fetch(32'h0000_0014, -1);
        fetch(32'h0000_0018, -1);
        fetch(32'h0000_001C, -1);
        check("t2_word3", m_data[1][3], 32'hA3);

        // Conflict miss evicts line 1, then the original address misses again.
        fetch(32'h0000_0110, -1);
        fetch(32'h0000_0010, -1);

        // Gapped burst.
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fetch(32'h0000_0234, -1);

        // Reset after two beats; the same address refills completely afterwards.
        fetch(32'h0000_2040, 2);
        fetch(32'h0000_2040, -1);
        fetch(32'h0000_0014, -1);

        // Spurious mem_valid while idle must not disturb the arrays.
        current_instr = 32'h0000_2044;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_rdata = $urandom;
            @(negedge CLK);
            check("spur_stall", 32'(Stall), 32'd0);
            check("spur_data", instr_out, m_data[4][1]);
            check("spur_memreq", 32'(mem_req), 32'd0);
            @(posedge CLK); #1;
        end
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) fetch(32'h0000_2040 + 32'(4 * i), -1);

        // Random fetches over a small tag space with random burst gaps.
        rand_gaps = 1'b1;
        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fetch(a, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
